bp_me_mem_cmd_arbiter: RTL and testbench
========================================

Name: bp_me_mem_cmd_arbiter

Overview:
- Shares one BedRock CCE memory command/response channel between num_req_p requesters, for example a CCE and an I/O master.
- Selects commands round-robin and holds each grant until the downstream handshake completes.
- Records the winner's ID in an in-order tag FIFO and routes each memory response back to that requester.
- Sits between requesters and the memory/DRAM model, upstream of the memory tracer tap.

Parameters:
- bp_params_p, e_bp_default_cfg: processor config; supplies paddr_width_p, cce_block_width_p, lce_id_width_p, lce_assoc_p and therefore cce_mem_msg_width_lp.
- num_req_p, 2: number of requesters (2..8).
- max_outstanding_p, 4: depth of the tag FIFO, i.e. the maximum number of commands in flight (power of 2).

Ports:
- clk_i  in  1  clock
- reset_i  in  1  reset, asynchronous, active-low
- mem_cmd_i  in  num_req_p*cce_mem_msg_width_lp  requester commands, packed with requester 0 in the LSBs
- mem_cmd_v_i  in  num_req_p  per-requester command valid
- mem_cmd_ready_o  out  num_req_p  per-requester command accept
- mem_cmd_o  out  cce_mem_msg_width_lp  granted command
- mem_cmd_v_o  out  1  downstream command valid
- mem_cmd_ready_i  in  1  downstream command ready
- mem_resp_i  in  cce_mem_msg_width_lp  memory response
- mem_resp_v_i  in  1  response valid
- mem_resp_yumi_o  out  1  response consumed
- mem_resp_o  out  cce_mem_msg_width_lp  response, broadcast to all requesters
- mem_resp_v_o  out  num_req_p  one-hot response valid
- mem_resp_yumi_i  in  num_req_p  per-requester response consume

Behaviour:
- Reset (reset_i=0, asynchronous): state=e_idle, rr_ptr=0, FIFO empty (rd=wr=0, count=0). All valid/ready/yumi outputs are 0. mem_cmd_o and mem_resp_o are don't-care.
- e_idle:
  - If the FIFO is not full and any mem_cmd_v_i is set, pick the first set bit scanning from rr_ptr upward with wrap-around.
  - Latch that index in gnt_r, push it into the tag FIFO, move to e_send.
  - mem_cmd_v_o is 0 in e_idle, so there is 1 cycle of arbitration latency.
- e_send:
  - mem_cmd_o = slice gnt_r of mem_cmd_i.
  - mem_cmd_v_o = 1.
  - mem_cmd_ready_o[gnt_r] = mem_cmd_ready_i; all other ready bits are 0.
  - On handshake (mem_cmd_ready_i=1): rr_ptr <= (gnt_r+1) mod num_req_p; return to e_idle.
  - The grant is never revoked mid-handshake. The requester must hold valid and message stable until accepted.
- Tag FIFO full (count==max_outstanding_p): no new grant. A pop in the same cycle does not enable a grant; the grant waits one more cycle.
- Response routing:
  - Memory returns responses in command order.
  - mem_resp_o = mem_resp_i.
  - mem_resp_v_o = onehot(head) & {num_req_p{mem_resp_v_i & ~empty}}.
  - mem_resp_yumi_o = mem_resp_yumi_i[head] & ~empty.
  - On yumi, pop the FIFO.
- Simultaneous push (grant) and pop (yumi) is legal: count is unchanged and pointers wrap mod max_outstanding_p.
- Response arriving while the FIFO is empty:
  - Not consumed: yumi_o=0 and all mem_resp_v_o=0.
  - Simulation-only assertion fires: "unexpected mem resp".
- Responses are not filtered by msg_type: rd, wr, uc_rd and uc_wr are all routed identically.
- Reset asserted mid-operation discards in-flight grants and tags. Downstream must be reset together with this block.
- count width is $clog2(max_outstanding_p+1); pointer width is $clog2(max_outstanding_p).

Decomposition:
- Shared package bp_me_pkg gets the state enum bp_me_arb_state_e {e_idle, e_send}.
- Message structs come from the existing `declare_bp_bedrock_mem_if macro; no new typedefs.
- Sub-module bp_me_arb_tag_fifo holds the ID FIFO: width $clog2(num_req_p), depth max_outstanding_p, with push/pop/full/empty/head.
- The round-robin scan stays inline.

Test Plan:
- Single requester: req0 issues uc_rd at address 0x8000_0000 with ready_i=1.
  - mem_cmd_v_o rises 1 cycle after v_i; cmd_o matches req0.
  - Response is later returned with mem_resp_v_o=2'b01; yumi passes through.
- Contention: both requesters valid every cycle, ready_i=1.
  - Grants alternate 0,1,0,1; the response order matches; 4 commands complete in 8 cycles.
- Backpressure: ready_i=0 for 5 cycles while in e_send.
  - gnt_r, cmd_o and v_o stay stable; req1 is not granted; the handshake completes on cycle 6.
- Full FIFO: 4 commands issued, no responses.
  - No 5th grant, mem_cmd_v_o stays 0.
  - Return 1 response: next grant occurs 1 cycle after the pop.
- Stray response: mem_resp_v_i=1 with the FIFO empty.
  - mem_resp_yumi_o=0, mem_resp_v_o=0, assertion logs an error.
- Asynchronous reset mid-e_send: drop reset_i low between clock edges.
  - Outputs go to 0 immediately; after release, state=e_idle and count=0.

Source files
------------

// File: rtl/bp_me_pkg.sv
// rtl/bp_me_pkg.sv - shared BedRock memory-engine types and message geometry
package bp_me_pkg;

  typedef enum logic [0:0] {
    e_bp_default_cfg = 1'b0
  } bp_params_e;

  typedef enum logic [0:0] {
    e_idle = 1'b0,
    e_send = 1'b1
  } bp_me_arb_state_e;

  localparam int bedrock_msg_type_width_gp    = 4;
  localparam int bedrock_msg_subop_width_gp   = 4;
  localparam int bedrock_msg_size_width_gp    = 3;
  localparam int bedrock_coh_state_width_gp   = 3;

  // Header is {payload, size, addr, subop, msg_type} with msg_type in the LSBs; data block sits above it.
  function automatic int bedrock_mem_msg_width(bp_params_e cfg);
    int paddr_w;
    int block_w;
    int lce_id_w;
    int assoc;
    unique case (cfg)
      e_bp_default_cfg: begin
        paddr_w  = 40;
        block_w  = 512;
        lce_id_w = 4;
        assoc    = 8;
      end
      default: begin
        paddr_w  = 40;
        block_w  = 512;
        lce_id_w = 4;
        assoc    = 8;
      end
    endcase
    return bedrock_msg_type_width_gp + bedrock_msg_subop_width_gp + paddr_w
         + bedrock_msg_size_width_gp + lce_id_w + $clog2(assoc)
         + bedrock_coh_state_width_gp + 1 + block_w;
  endfunction

endpackage

// File: rtl/bp_me_arb_tag_fifo.sv
// rtl/bp_me_arb_tag_fifo.sv - in-order FIFO of granted requester IDs
module bp_me_arb_tag_fifo
  import bp_me_pkg::*;
#(
  parameter int width_p = 1,
  parameter int els_p   = 4
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               push_i,
  input  logic [width_p-1:0] data_i,
  input  logic               pop_i,
  output logic               full_o,
  output logic               empty_o,
  output logic [width_p-1:0] head_o
);

  localparam int ptr_width_lp = $clog2(els_p);
  localparam int cnt_width_lp = $clog2(els_p + 1);

  logic [width_p-1:0]      mem_q [els_p];
  logic [width_p-1:0]      mem_d [els_p];
  logic [ptr_width_lp-1:0] rd_ptr_q, rd_ptr_d;
  logic [ptr_width_lp-1:0] wr_ptr_q, wr_ptr_d;
  logic [cnt_width_lp-1:0] count_q, count_d;
  logic                    do_push, do_pop;

  assign full_o  = (count_q == cnt_width_lp'(els_p));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = data_i;
      wr_ptr_d        = wr_ptr_q + ptr_width_lp'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + ptr_width_lp'(1);
    end
    // Pointers wrap naturally because depth is a power of two.
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + cnt_width_lp'(1);
      2'b01:   count_d = count_q - cnt_width_lp'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/bp_me_mem_cmd_arbiter.sv
// rtl/bp_me_mem_cmd_arbiter.sv - round-robin share of one BedRock memory cmd/resp channel
module bp_me_mem_cmd_arbiter
  import bp_me_pkg::*;
#(
  parameter bp_params_e bp_params_p       = e_bp_default_cfg,
  parameter int         num_req_p         = 2,
  parameter int         max_outstanding_p = 4,
  parameter bit         sim_assert_p      = 1'b1,
  localparam int        cce_mem_msg_width_lp = bedrock_mem_msg_width(bp_params_p),
  localparam int        id_width_lp          = $clog2(num_req_p)
) (
  input  logic                                      clk_i,
  input  logic                                      reset_i,
  input  logic [num_req_p*cce_mem_msg_width_lp-1:0] mem_cmd_i,
  input  logic [num_req_p-1:0]                      mem_cmd_v_i,
  output logic [num_req_p-1:0]                      mem_cmd_ready_o,
  output logic [cce_mem_msg_width_lp-1:0]           mem_cmd_o,
  output logic                                      mem_cmd_v_o,
  input  logic                                      mem_cmd_ready_i,
  input  logic [cce_mem_msg_width_lp-1:0]           mem_resp_i,
  input  logic                                      mem_resp_v_i,
  output logic                                      mem_resp_yumi_o,
  output logic [cce_mem_msg_width_lp-1:0]           mem_resp_o,
  output logic [num_req_p-1:0]                      mem_resp_v_o,
  input  logic [num_req_p-1:0]                      mem_resp_yumi_i
);

  bp_me_arb_state_e                                 state_q, state_d;
  logic [id_width_lp-1:0]                           gnt_q, gnt_d;
  logic [id_width_lp-1:0]                           rr_ptr_q, rr_ptr_d;
  logic [id_width_lp-1:0]                           pick_id;
  logic                                             pick_v;
  logic                                             fifo_push, fifo_full, fifo_empty;
  logic [id_width_lp-1:0]                           fifo_head;
  logic [num_req_p-1:0][cce_mem_msg_width_lp-1:0]   cmd_arr;

  assign cmd_arr = mem_cmd_i;

  // First valid requester at or after rr_ptr; scanning high-to-low lets the nearest one win.
  always_comb begin
    logic [id_width_lp:0] idx;
    idx     = '0;
    pick_v  = 1'b0;
    pick_id = '0;
    for (int i = num_req_p - 1; i >= 0; i--) begin
      idx = {1'b0, rr_ptr_q} + (id_width_lp + 1)'(i);
      if (idx >= (id_width_lp + 1)'(num_req_p)) begin
        idx = idx - (id_width_lp + 1)'(num_req_p);
      end
      if (mem_cmd_v_i[idx[id_width_lp-1:0]]) begin
        pick_v  = 1'b1;
        pick_id = idx[id_width_lp-1:0];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    rr_ptr_d  = rr_ptr_q;
    fifo_push = 1'b0;
    unique case (state_q)
      e_idle: begin
        if (pick_v && !fifo_full) begin
          fifo_push = 1'b1;
          gnt_d     = pick_id;
          state_d   = e_send;
        end
      end
      e_send: begin
        if (mem_cmd_ready_i) begin
          rr_ptr_d = (gnt_q == id_width_lp'(num_req_p - 1)) ? '0 : gnt_q + id_width_lp'(1);
          state_d  = e_idle;
        end
      end
      default: state_d = e_idle;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q  <= e_idle;
      gnt_q    <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign mem_cmd_o   = cmd_arr[gnt_q];
  assign mem_cmd_v_o = (state_q == e_send);

  always_comb begin
    mem_cmd_ready_o = '0;
    if (state_q == e_send) begin
      mem_cmd_ready_o[gnt_q] = mem_cmd_ready_i;
    end
  end

  // Responses return in command order, so the FIFO head names the owner.
  assign mem_resp_o      = mem_resp_i;
  assign mem_resp_yumi_o = mem_resp_yumi_i[fifo_head] & ~fifo_empty;

  always_comb begin
    mem_resp_v_o = '0;
    if (mem_resp_v_i && !fifo_empty) begin
      mem_resp_v_o[fifo_head] = 1'b1;
    end
  end

  bp_me_arb_tag_fifo #(
    .width_p (id_width_lp),
    .els_p   (max_outstanding_p)
  ) tag_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push_i  (fifo_push),
    .data_i  (pick_id),
    .pop_i   (mem_resp_yumi_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (fifo_head)
  );

`ifndef SYNTHESIS
  if (sim_assert_p) begin : g_stray_resp_assert
    stray_resp_a : assert property (@(posedge clk_i) disable iff (!reset_i)
      !(mem_resp_v_i && fifo_empty))
      else $error("unexpected mem resp");
  end
`endif

endmodule

// File: tb/tb_bp_me_mem_cmd_arbiter.sv
// tb/tb_bp_me_mem_cmd_arbiter.sv - randomized self-checking bench for bp_me_mem_cmd_arbiter
module tb_bp_me_mem_cmd_arbiter;
  import bp_me_pkg::*;

  localparam int W    = bedrock_mem_msg_width(e_bp_default_cfg);
  localparam int N    = 2;
  localparam int MAXO = 4;
  typedef logic [W-1:0] msg_t;

  logic           clk_i = 1'b0;
  logic           reset_i = 1'b0;
  logic [N*W-1:0] mem_cmd_i;
  logic [N-1:0]   mem_cmd_v_i;
  logic [N-1:0]   mem_cmd_ready_o;
  msg_t           mem_cmd_o;
  logic           mem_cmd_v_o;
  logic           mem_cmd_ready_i;
  msg_t           mem_resp_i;
  logic           mem_resp_v_i;
  logic           mem_resp_yumi_o;
  msg_t           mem_resp_o;
  logic [N-1:0]   mem_resp_v_o;
  logic [N-1:0]   mem_resp_yumi_i;

  bp_me_mem_cmd_arbiter #(
    .bp_params_p       (e_bp_default_cfg),
    .num_req_p         (N),
    .max_outstanding_p (MAXO),
    .sim_assert_p      (1'b0)
  ) dut (
    .clk_i           (clk_i),
    .reset_i         (reset_i),
    .mem_cmd_i       (mem_cmd_i),
    .mem_cmd_v_i     (mem_cmd_v_i),
    .mem_cmd_ready_o (mem_cmd_ready_o),
    .mem_cmd_o       (mem_cmd_o),
    .mem_cmd_v_o     (mem_cmd_v_o),
    .mem_cmd_ready_i (mem_cmd_ready_i),
    .mem_resp_i      (mem_resp_i),
    .mem_resp_v_i    (mem_resp_v_i),
    .mem_resp_yumi_o (mem_resp_yumi_o),
    .mem_resp_o      (mem_resp_o),
    .mem_resp_v_o    (mem_resp_v_o),
    .mem_resp_yumi_i (mem_resp_yumi_i)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Requester queues, memory-side queue, and the abstract arbiter model.
  msg_t req_q [N][$];
  msg_t mem_q [$];
  int   tag_q [$];
  int   dut_log [$];
  bit   m_busy;
  int   m_gnt;
  int   m_rr;
  bit   resp_pres;
  bit   stray;
  int   p_ready, p_resp, p_yumi;

  function automatic msg_t mk_msg(int id, int mtype);
    msg_t m;
    m = '0;
    repeat ((W + 31) / 32) m = {m[W-33:0], 32'($urandom)};
    m[3:0] = 4'(mtype);
    m[7:4] = 4'(id);
    return m;
  endfunction

  function automatic msg_t resp_of(msg_t c);
    msg_t top;
    top = '0;
    top[W-1] = 1'b1;
    return c ^ top;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < N; r++) req_q[r].delete();
    mem_q.delete();
    tag_q.delete();
    m_busy    = 1'b0;
    m_gnt     = 0;
    m_rr      = 0;
    resp_pres = 1'b0;
  endtask

  task automatic drive();
    for (int r = 0; r < N; r++) begin
      mem_cmd_v_i[r]      = (req_q[r].size() > 0);
      mem_cmd_i[r*W +: W] = (req_q[r].size() > 0) ? req_q[r][0] : '0;
    end
    mem_cmd_ready_i = (int'($urandom_range(99)) < p_ready);
    if (stray) begin
      mem_resp_v_i = 1'b1;
      mem_resp_i   = mk_msg(0, 0);
    end else begin
      if (mem_q.size() > 0 && !resp_pres && int'($urandom_range(99)) < p_resp) resp_pres = 1'b1;
      mem_resp_v_i = resp_pres;
      mem_resp_i   = resp_pres ? resp_of(mem_q[0]) : '0;
    end
    mem_resp_yumi_i = '0;
    if (mem_resp_v_i) begin
      for (int r = 0; r < N; r++) mem_resp_yumi_i[r] = (int'($urandom_range(99)) < p_yumi);
    end
  endtask

  // Evaluated mid-cycle: compare outputs, then advance the model to the next edge.
  task automatic model_step();
    logic [N-1:0] exp_ready, exp_rv, route;
    bit pop, full;
    int head, win;
    exp_ready = '0;
    exp_rv    = '0;
    pop       = 1'b0;
    head      = 0;
    chk("cmd_v", mem_cmd_v_o, m_busy);
    if (m_busy) begin
      chk("cmd_msg", mem_cmd_o, req_q[m_gnt][0]);
      if (mem_cmd_ready_i) exp_ready[m_gnt] = 1'b1;
    end
    chk("cmd_ready", mem_cmd_ready_o, exp_ready);
    if (tag_q.size() > 0) begin
      head = tag_q[0];
      if (mem_resp_v_i) exp_rv[head] = 1'b1;
      pop = mem_resp_yumi_i[head];
    end
    chk("resp_v", mem_resp_v_o, exp_rv);
    chk("resp_yumi", mem_resp_yumi_o, pop);
    chk("resp_data", mem_resp_o, mem_resp_i);
    if (mem_resp_v_i && tag_q.size() > 0 && !stray) begin
      route = '0;
      route[mem_resp_i[7:4]] = 1'b1;
      chk("resp_route", mem_resp_v_o, route);
    end
    if (mem_cmd_v_o && mem_cmd_ready_i) dut_log.push_back(int'(mem_cmd_o[7:4]));

    full = (tag_q.size() == MAXO);
    if (pop) begin
      void'(tag_q.pop_front());
      void'(mem_q.pop_front());
      resp_pres = 1'b0;
    end
    if (m_busy) begin
      if (mem_cmd_ready_i) begin
        mem_q.push_back(req_q[m_gnt].pop_front());
        m_rr   = (m_gnt + 1) % N;
        m_busy = 1'b0;
      end
    end else if (!full) begin
      win = -1;
      for (int k = 0; k < N; k++) begin
        int r;
        r = (m_rr + k) % N;
        if (win < 0 && req_q[r].size() > 0) win = r;
      end
      if (win >= 0) begin
        m_busy = 1'b1;
        m_gnt  = win;
        tag_q.push_back(win);
      end
    end
  endtask

  task automatic cycle();
    drive();
    @(negedge clk_i);
    model_step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    p_ready = 100; p_resp = 100; p_yumi = 100;
    while ((m_busy || tag_q.size() > 0 || req_q[0].size() > 0 || req_q[1].size() > 0) && budget < 300) begin
      cycle();
      budget++;
    end
    chk("drain_timeout", budget < 300, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    stray = 1'b0;
    p_ready = 100; p_resp = 0; p_yumi = 100;
    mem_cmd_i = '0; mem_cmd_v_i = '1; mem_cmd_ready_i = 1'b1;
    mem_resp_i = '0; mem_resp_v_i = 1'b1; mem_resp_yumi_i = '1;
    #12;
    chk("rst_cmd_v", mem_cmd_v_o, 1'b0);
    chk("rst_cmd_ready", mem_cmd_ready_o, '0);
    chk("rst_resp_v", mem_resp_v_o, '0);
    chk("rst_resp_yumi", mem_resp_yumi_o, 1'b0);
    @(posedge clk_i); #1;
    reset_i = 1'b1;

    // Single requester: uncached read to 0x8000_0000.
    begin
      msg_t m;
      m = mk_msg(0, 2);
      m[8 +: 40] = 40'h00_8000_0000;
      req_q[0].push_back(m);
    end
    repeat (3) cycle();
    p_resp = 100;
    drain();

    // Asynchronous reset while a grant is being presented.
    req_q[0].push_back(mk_msg(0, 0));
    p_ready = 0; p_resp = 0;
    repeat (2) cycle();
    drive();
    chk("pre_reset_cmd_v", mem_cmd_v_o, 1'b1);
    mem_cmd_ready_i = 1'b1; mem_resp_v_i = 1'b1; mem_resp_yumi_i = '1;
    #2 reset_i = 1'b0;
    #1;
    chk("async_cmd_v", mem_cmd_v_o, 1'b0);
    chk("async_cmd_ready", mem_cmd_ready_o, '0);
    chk("async_resp_v", mem_resp_v_o, '0);
    chk("async_resp_yumi", mem_resp_yumi_o, 1'b0);
    model_reset();
    @(posedge clk_i); #1;
    reset_i = 1'b1;
    stray = 1'b1; p_yumi = 100;
    req_q[1].push_back(mk_msg(1, 1));
    cycle();
    stray = 1'b0;
    drain();

    // Contention: both requesters always valid, fresh round-robin pointer.
    model_reset();
    reset_i = 1'b0;
    @(posedge clk_i); #1;
    reset_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      req_q[0].push_back(mk_msg(0, k));
      req_q[1].push_back(mk_msg(1, k + 1));
    end
    dut_log.delete();
    p_ready = 100; p_resp = 100; p_yumi = 100;
    repeat (8) cycle();
    chk("contention_count", dut_log.size(), 4);
    if (dut_log.size() >= 4) begin
      for (int k = 0; k < 4; k++) chk("contention_order", dut_log[k], k % 2);
    end
    drain();

    // Backpressure: five stalled cycles in send, completion on the sixth.
    req_q[0].push_back(mk_msg(0, 3));
    req_q[1].push_back(mk_msg(1, 2));
    dut_log.delete();
    p_ready = 0;
    repeat (6) cycle();
    chk("bp_no_handshake", dut_log.size(), 0);
    p_ready = 100;
    cycle();
    chk("bp_handshake", dut_log.size(), 1);
    if (dut_log.size() >= 1) chk("bp_winner", dut_log[0], 0);
    drain();

    // Full tag FIFO: four in flight, fifth waits until one response pops.
    for (int k = 0; k < 3; k++) req_q[0].push_back(mk_msg(0, k));
    for (int k = 0; k < 2; k++) req_q[1].push_back(mk_msg(1, k));
    dut_log.delete();
    p_ready = 100; p_resp = 0; p_yumi = 100;
    repeat (12) cycle();
    chk("full_count", dut_log.size(), 4);
    p_resp = 100;
    cycle();
    p_resp = 0;
    cycle();
    chk("full_still_4", dut_log.size(), 4);
    cycle();
    chk("full_fifth", dut_log.size(), 5);
    drain();

    // Stray response with nothing outstanding.
    stray = 1'b1;
    repeat (2) cycle();
    stray = 1'b0;

    // Randomized traffic.
    for (int c = 0; c < 400; c++) begin
      int r;
      r = int'($urandom_range(N - 1));
      if (int'($urandom_range(99)) < 35 && req_q[r].size() < 4) req_q[r].push_back(mk_msg(r, int'($urandom_range(3))));
      p_ready = 60; p_resp = 50; p_yumi = 70;
      cycle();
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
